// File: rtl/rgb2hsv_pkg.sv
// Shared constants, latency helper and per-stage sideband payload for the RGB->HSV pipeline.
package rgb2hsv_pkg;
  localparam int HUE_OFF_R = 0;
  localparam int HUE_OFF_G = 120;
  localparam int HUE_OFF_B = 240;
  localparam int HUE_FULL  = 360;
  localparam int HUE_SCALE = 60;

  // Widest component and sideband the payload struct can carry.
  localparam int DW_MAX = 12;
  localparam int SB_MAX = 8;

  function automatic int lat(input int dw);
    return dw + 3;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [SB_MAX-1:0] sb;
    logic [8:0]        off;
    logic              neg;
    logic [DW_MAX-1:0] max;
  } hsv_side_t;
endpackage

// File: rtl/rgb2hsv_if.sv
// Pixel stream bundle: stall enable, qualified RGB input with sideband, HSV result.
interface rgb2hsv_if #(
  parameter int DW  = 8,
  parameter int SBW = 2
);
  logic            en;
  logic            in_valid;
  logic [3*DW-1:0] in_rgb;
  logic [SBW-1:0]  in_sb;
  logic            out_valid;
  logic [8:0]      out_h;
  logic [DW-1:0]   out_s;
  logic [DW-1:0]   out_v;
  logic [SBW-1:0]  out_sb;

  modport master (
    output en, in_valid, in_rgb, in_sb,
    input  out_valid, out_h, out_s, out_v, out_sb
  );

  modport slave (
    input  en, in_valid, in_rgb, in_sb,
    output out_valid, out_h, out_s, out_v, out_sb
  );
endinterface

// File: rtl/div_pipe.sv
// Pipelined restoring divider: one quotient bit per stage, MSB first, QW stages of latency.
module div_pipe #(
  parameter int NUMW = 14,
  parameter int DENW = 8,
  parameter int QW   = 8
) (
  input  logic            pclk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [NUMW-1:0] num,
  input  logic [DENW-1:0] den,
  output logic [QW-1:0]   quo
);
  // Wide enough for the dividend and for the divisor shifted by the top quotient bit.
  localparam int W = (NUMW > DENW + QW) ? NUMW : DENW + QW;

  for (genvar j = 0; j < QW; j++) begin : g_st
    logic [W-1:0]    rem_q, rem_in, trial;
    logic [DENW-1:0] den_q, den_in;
    logic [QW-1:0]   quo_q, quo_in;

    if (j == 0) begin : g_first
      assign rem_in = W'(num);
      assign den_in = den;
      assign quo_in = '0;
    end else begin : g_next
      assign rem_in = g_st[j-1].rem_q;
      assign den_in = g_st[j-1].den_q;
      assign quo_in = g_st[j-1].quo_q;
    end

    assign trial = W'(den_in) << (QW - 1 - j);

    // stage j: resolve quotient bit QW-1-j
    always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
        rem_q <= '0;
        den_q <= '0;
        quo_q <= '0;
      end else if (en) begin
        den_q <= den_in;
        if (rem_in >= trial) begin
          rem_q <= rem_in - trial;
          quo_q <= quo_in | (QW'(1) << (QW - 1 - j));
        end else begin
          rem_q <= rem_in;
          quo_q <= quo_in;
        end
      end
    end
  end

  assign quo = g_st[QW-1].quo_q;

  logic tail_unused;
  assign tail_unused = ^{g_st[QW-1].rem_q, g_st[QW-1].den_q};
endmodule

// File: rtl/rgb2hsv_pipe.sv
// Fully pipelined RGB->HSV converter, DW+3 enabled cycles of latency, sideband delayed in lock-step.
module rgb2hsv_pipe
  import rgb2hsv_pkg::*;
#(
  parameter int DW       = 8,
  parameter int HUE_MODE = 0,
  parameter int SBW      = 2
) (
  input logic      pclk,
  input logic      rst_n,
  rgb2hsv_if.slave bus
);
  function automatic logic [8:0] hue_out(input logic [8:0] off, input logic neg,
                                         input logic [DW-1:0] q);
    logic signed [9:0] deg;
    deg = neg ? ($signed({1'b0, off}) - $signed(10'(q)))
              : ($signed({1'b0, off}) + $signed(10'(q)));
    if (deg >= 10'sd360) deg = deg - 10'sd360;
    return (HUE_MODE != 0) ? 9'(deg) : 9'(deg >>> 1);
  endfunction

  // stage 0: input register
  logic [3*DW-1:0] rgb_p0;
  logic            vld_p0;
  logic [SBW-1:0]  sb_p0;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      sb_p0  <= '0;
    end else if (bus.en) begin
      vld_p0 <= bus.in_valid;
      sb_p0  <= bus.in_sb;
    end
  end

  always_ff @(posedge pclk) begin
    if (bus.en) rgb_p0 <= bus.in_rgb;
  end

  // stage 1: max/min, hue sector and divider operands
  logic [DW-1:0] r, g, b, mx, mn, num, delta;
  logic          neg;
  logic [8:0]    off;

  assign {r, g, b} = rgb_p0;

  always_comb begin
    mx  = r;
    num = '0;
    neg = 1'b0;
    off = 9'(HUE_OFF_R);
    if (r >= g && r >= b) begin
      mx  = r;
      neg = g < b;
      num = neg ? b - g : g - b;
      off = neg ? 9'(HUE_FULL) : 9'(HUE_OFF_R);
    end else if (g >= b) begin
      mx  = g;
      neg = b < r;
      num = neg ? r - b : b - r;
      off = 9'(HUE_OFF_G);
    end else begin
      mx  = b;
      neg = r < g;
      num = neg ? g - r : r - g;
      off = 9'(HUE_OFF_B);
    end
    mn    = (r <= g && r <= b) ? r : ((g <= b) ? g : b);
    delta = mx - mn;
  end

  logic [DW+5:0]   hnum_p1;
  logic [DW-1:0]   hden_p1, sden_p1;
  logic [2*DW-1:0] snum_p1;
  hsv_side_t       side_p1;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      side_p1.valid <= 1'b0;
      side_p1.sb    <= '0;
    end else if (bus.en) begin
      side_p1 <= '{valid: vld_p0, sb: SB_MAX'(sb_p0), off: off, neg: neg, max: DW_MAX'(mx)};
    end
  end

  // Gray and black force a 0/1 division so neither divider ever sees a zero divisor.
  always_ff @(posedge pclk) begin
    if (bus.en) begin
      if (delta == '0) begin
        hnum_p1 <= '0;
        hden_p1 <= DW'(1);
        snum_p1 <= '0;
        sden_p1 <= DW'(1);
      end else begin
        hnum_p1 <= (DW+6)'(num) * (DW+6)'(HUE_SCALE);
        hden_p1 <= delta;
        snum_p1 <= {delta, {DW{1'b0}}} - (2*DW)'(delta);
        sden_p1 <= mx;
      end
    end
  end

  // stages 2..DW+1: dividers with the payload shifted alongside
  logic [DW-1:0] hue_q, sat_q;
  hsv_side_t     side_pd [DW];

  div_pipe #(.NUMW(DW+6), .DENW(DW), .QW(DW)) u_hue_div (
    .pclk(pclk), .rst_n(rst_n), .en(bus.en), .num(hnum_p1), .den(hden_p1), .quo(hue_q)
  );

  div_pipe #(.NUMW(2*DW), .DENW(DW), .QW(DW)) u_sat_div (
    .pclk(pclk), .rst_n(rst_n), .en(bus.en), .num(snum_p1), .den(sden_p1), .quo(sat_q)
  );

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DW; i++) begin
        side_pd[i].valid <= 1'b0;
        side_pd[i].sb    <= '0;
      end
    end else if (bus.en) begin
      side_pd[0] <= side_p1;
      for (int i = 1; i < DW; i++) side_pd[i] <= side_pd[i-1];
    end
  end

  // stage DW+2: hue assembly and output register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_h     <= '0;
      bus.out_s     <= '0;
      bus.out_v     <= '0;
      bus.out_sb    <= '0;
    end else if (bus.en) begin
      bus.out_valid <= side_pd[DW-1].valid;
      bus.out_h     <= hue_out(side_pd[DW-1].off, side_pd[DW-1].neg, hue_q);
      bus.out_s     <= sat_q;
      bus.out_v     <= side_pd[DW-1].max[DW-1:0];
      bus.out_sb    <= side_pd[DW-1].sb[SBW-1:0];
    end
  end

  logic side_unused;
  assign side_unused = ^{side_pd[DW-1].sb, side_pd[DW-1].max};
endmodule
